wb_sram16_ctrl: RTL
===================

// Module: wb_sram16_ctrl
// PURPOSE
//  Wishbone slave downstream of the bus interconnect; owns one slave port (sN_*).
//  Converts each 32-bit Wishbone access into two sequenced accesses on an external
//  async 16-bit SRAM with programmable wait states. Low halfword first.
//  Optionally shortens back-to-back incrementing read bursts.
// PARAMETERS
//  SRAM_AW  18  SRAM halfword address width; Wishbone byte span = 2^(SRAM_AW+1)
//  RD_WAIT  2   cycles oe_n held low per half before data is sampled (min 1)
//  WR_WAIT  2   cycles we_n held low per half (min 1)
// PORTS
//  sys_clk     in   1        clock
//  sys_rst     in   1        reset, asynchronous, active-high
//  wb_adr_i    in   32       byte address; only [SRAM_AW:2] used, upper bits decoded upstream
//  wb_dat_i    in   32       write data
//  wb_dat_o    out  32       read data, registered
//  wb_sel_i    in   4        byte selects
//  wb_cti_i    in   3        cycle type
//  wb_we_i     in   1        write enable
//  wb_cyc_i    in   1        cycle
//  wb_stb_i    in   1        strobe
//  wb_ack_o    out  1        acknowledge, registered, one cycle per beat
//  sram_addr   out  SRAM_AW  halfword address = {wb_adr_i[SRAM_AW:2], half}
//  sram_dq_o   out  16       write data to pad
//  sram_dq_i   in   16       read data from pad
//  sram_dq_oe  out  1        pad output enable (1 = drive)
//  sram_ce_n / sram_oe_n / sram_we_n  out 1 each, active-low strobes
//  sram_be_n   out  2        byte enables, active-low
// BEHAVIOUR
//  - Reset (async): ce_n=oe_n=we_n=1, be_n=2'b11, dq_oe=0, sram_addr=0, dq_o=0,
//    wb_ack_o=0, wb_dat_o=0, FSM=IDLE, wait counter=0.
//  - FSM: IDLE, LO_ACC, LO_HOLD, HI_ACC, HI_HOLD, ACK.
//  - IDLE: cyc&stb sampled -> latch adr/dat/sel/we/cti; go LO_ACC; ce_n=0.
//  - LO_ACC/HI_ACC: half=0/1; be_n=~sel[1:0] / ~sel[3:2]; counter loads RD_WAIT or WR_WAIT.
//    Read: oe_n=0, dq_oe=0; on last wait cycle capture sram_dq_i into wb_dat_o[15:0]/[31:16].
//    Write: dq_oe=1, dq_o=dat half, we_n=0 for WR_WAIT cycles.
//  - LO_HOLD/HI_HOLD (writes only): we_n=1, addr and data held 1 cycle. Reads skip HOLD.
//  - Halves with zero sel are still cycled, with be_n=2'b11.
//  - ACK: wb_ack_o=1 for exactly one cycle; strobes inactive; next IDLE.
//  - Latency from request edge to ack cycle: read 2*RD_WAIT+1, write 2*WR_WAIT+3.
//  - cyc_i low in any non-IDLE state: next cycle IDLE, all strobes inactive, dq_oe=0, no ack.
//    wb_dat_o is held. stb_i low with cyc_i high does not abort.
//  - cti_i is ignored unless SRAM_CTRL_BURST_EN is defined. Never more than one ack per beat.
// CONFIGURATION
//  SRAM_CTRL_BURST_EN defined:
//    - Read in ACK with latched cti=3'b010 and cyc_i&stb_i still high: go straight to LO_ACC.
//      Internal address is incremented by 4, wrapping at 2^(SRAM_AW+1). No IDLE cycle.
//    - Beat period = 2*RD_WAIT+1.
//    - Burst ends on ack of a cti=3'b111 or 3'b000 beat, or when cyc drops.
//    - Writes are always classic.
//  SRAM_CTRL_BURST_EN undefined: every beat returns through IDLE; period 2*RD_WAIT+2.
// STRUCTURE
//  - Shared header sram_ctrl_defs.vh: FSM state encodings; CTI_CLASSIC=3'b000,
//    CTI_INCR=3'b010, CTI_EOB=3'b111.
//  - One sub-module, wb_sram16_timer: loadable down-counter with done flag. FSM and
//    datapath live in the top module.
// TESTING
//  1. Read, RD_WAIT=2: SRAM[0x100]=0x1234, SRAM[0x101]=0xABCD; read adr 0x200
//     -> wb_dat_o=0xABCD1234; single ack 5 cycles after the request edge.
//  2. Write 0xDEADBEEF, sel=4'b0100, adr 0x8, WR_WAIT=2
//     -> lo half: addr 0x4, be_n=11; hi half: addr 0x5, be_n=2'b10, dq_o=0xDEAD;
//     ack at cycle 7; SRAM byte 0x0A=0xAD, others unchanged.
//  3. Drop cyc in HI_ACC of a read -> no ack; ce_n=oe_n=1 next cycle.
//     A following read at 0x0 completes normally.
//  4. Assert sys_rst mid-write (we_n=0) -> we_n=1, dq_oe=0, ack=0 immediately,
//     without waiting for a clock edge.
//  5. SRAM_CTRL_BURST_EN defined: 4-beat read at 0x0 with cti 010,010,010,111
//     -> 4 acks spaced 5 cycles, data SRAM[0..7]. Without the macro, acks spaced 6 cycles.
//  6. RD_WAIT=1, read at top address (2^(SRAM_AW+1))-4 -> ack after 3 cycles;
//     with burst on, next beat wraps to address 0.

Source files
------------

// File: rtl/wb_sram16_ctrl_pkg.sv
// Shared types and constants for the Wishbone-to-16-bit async SRAM controller.
// FSM state encoding, Wishbone cycle-type codes and the byte-enable helper.
package wb_sram16_ctrl_pkg;

  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LO_ACC  = 3'd1,
    ST_LO_HOLD = 3'd2,
    ST_HI_ACC  = 3'd3,
    ST_HI_HOLD = 3'd4,
    ST_ACK     = 3'd5
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Active-low byte enables for one halfword of a 32-bit access.
  function automatic logic [1:0] half_be_n(input logic [3:0] sel, input logic half);
    logic [1:0] be_n;
    if (half) begin
      be_n = ~sel[3:2];
    end else begin
      be_n = ~sel[1:0];
    end
    return be_n;
  endfunction

endpackage

// File: rtl/wb_sram16_timer.sv
// Loadable wait-state down-counter; done marks the last cycle of a strobe window.
module wb_sram16_timer
  import wb_sram16_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt_r;

  // Counter: load wins over decrement; parks at zero when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {TMR_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {TMR_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {TMR_W{1'b0}}) begin
      cnt_r <= cnt_r - TMR_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == TMR_W'(1));

endmodule

// File: rtl/wb_sram16_ctrl.sv
// Wishbone slave driving an async 16-bit SRAM as two halfword accesses, low half first.
// Define SRAM_CTRL_BURST_EN to chain incrementing read bursts without an IDLE cycle.
module wb_sram16_ctrl
  import wb_sram16_ctrl_pkg::*;
#(
  parameter int SRAM_AW = 18,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  input  logic [3:0]         wb_sel_i,
  input  logic [2:0]         wb_cti_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic               wb_ack_o,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [1:0]         sram_be_n
);

  localparam int WAW = SRAM_AW - 1;

  state_e           state_r;
  logic [WAW-1:0]   adr_r;
  logic [31:0]      dat_r;
  logic [3:0]       sel_r;
  logic             we_r;
  logic [2:0]       cti_r;

  logic             req_s;
  logic             abort_s;
  logic             burst_go_s;
  logic             tmr_load_s;
  logic             tmr_done_s;
  logic [TMR_W-1:0] tmr_val_s;
  logic             unused_s;

  assign req_s   = wb_cyc_i & wb_stb_i;
  assign abort_s = (state_r != ST_IDLE) & ~wb_cyc_i;

`ifdef SRAM_CTRL_BURST_EN
  assign burst_go_s = (state_r == ST_ACK) & ~we_r & (cti_r == CTI_INCR) & req_s;
`else
  assign burst_go_s = 1'b0;
`endif

  // Address bits outside the SRAM window are decoded upstream.
  assign unused_s = ^{wb_adr_i[31:SRAM_AW+1], wb_adr_i[1:0], cti_r};

  // Timer load: at the start of every strobe window.
  always_comb begin
    tmr_load_s = 1'b0;
    if ((state_r == ST_IDLE) ? wb_we_i : we_r) begin
      tmr_val_s = TMR_W'(WR_WAIT);
    end else begin
      tmr_val_s = TMR_W'(RD_WAIT);
    end
    if (abort_s) begin
      tmr_load_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:    tmr_load_s = req_s;
        ST_LO_ACC:  tmr_load_s = tmr_done_s & ~we_r;
        ST_LO_HOLD: tmr_load_s = 1'b1;
        ST_ACK:     tmr_load_s = burst_go_s;
        default:    tmr_load_s = 1'b0;
      endcase
    end
  end

  wb_sram16_timer u_timer (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .load     (tmr_load_s),
    .clear    (abort_s),
    .load_val (tmr_val_s),
    .done     (tmr_done_s)
  );

  // Main FSM with registered SRAM strobes, address, pad data and Wishbone outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r    <= ST_IDLE;
      adr_r      <= {WAW{1'b0}};
      dat_r      <= 32'h0000_0000;
      sel_r      <= 4'b0000;
      we_r       <= 1'b0;
      cti_r      <= CTI_CLASSIC;
      wb_dat_o   <= 32'h0000_0000;
      wb_ack_o   <= 1'b0;
      sram_addr  <= {SRAM_AW{1'b0}};
      sram_dq_o  <= 16'h0000;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 2'b11;
    end else begin
      wb_ack_o <= 1'b0;
      if (abort_s) begin
        // Master gave up: release the SRAM, keep the last read data.
        state_r    <= ST_IDLE;
        sram_ce_n  <= 1'b1;
        sram_oe_n  <= 1'b1;
        sram_we_n  <= 1'b1;
        sram_be_n  <= 2'b11;
        sram_dq_oe <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (req_s) begin
              adr_r      <= wb_adr_i[SRAM_AW:2];
              dat_r      <= wb_dat_i;
              sel_r      <= wb_sel_i;
              we_r       <= wb_we_i;
              cti_r      <= wb_cti_i;
              sram_addr  <= {wb_adr_i[SRAM_AW:2], 1'b0};
              sram_be_n  <= half_be_n(wb_sel_i, 1'b0);
              sram_dq_o  <= wb_dat_i[15:0];
              sram_dq_oe <= wb_we_i;
              sram_ce_n  <= 1'b0;
              sram_oe_n  <= wb_we_i;
              sram_we_n  <= ~wb_we_i;
              state_r    <= ST_LO_ACC;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_LO_ACC: begin
            if (tmr_done_s && we_r) begin
              sram_we_n <= 1'b1;
              state_r   <= ST_LO_HOLD;
            end else if (tmr_done_s) begin
              // Mid-beat is where a burst master shows this beat's cycle type.
              wb_dat_o[15:0] <= sram_dq_i;
              cti_r          <= wb_cti_i;
              sram_addr      <= {adr_r, 1'b1};
              sram_be_n      <= half_be_n(sel_r, 1'b1);
              state_r        <= ST_HI_ACC;
            end else begin
              state_r <= ST_LO_ACC;
            end
          end
          ST_LO_HOLD: begin
            sram_addr <= {adr_r, 1'b1};
            sram_be_n <= half_be_n(sel_r, 1'b1);
            sram_dq_o <= dat_r[31:16];
            sram_we_n <= 1'b0;
            state_r   <= ST_HI_ACC;
          end
          ST_HI_ACC: begin
            if (tmr_done_s && we_r) begin
              sram_we_n <= 1'b1;
              state_r   <= ST_HI_HOLD;
            end else if (tmr_done_s) begin
              wb_dat_o[31:16] <= sram_dq_i;
              wb_ack_o        <= 1'b1;
              sram_ce_n       <= 1'b1;
              sram_oe_n       <= 1'b1;
              sram_be_n       <= 2'b11;
              state_r         <= ST_ACK;
            end else begin
              state_r <= ST_HI_ACC;
            end
          end
          ST_HI_HOLD: begin
            wb_ack_o   <= 1'b1;
            sram_ce_n  <= 1'b1;
            sram_be_n  <= 2'b11;
            sram_dq_oe <= 1'b0;
            state_r    <= ST_ACK;
          end
          ST_ACK: begin
            if (burst_go_s) begin
              adr_r     <= adr_r + WAW'(1);
              sel_r     <= wb_sel_i;
              sram_addr <= {adr_r + WAW'(1), 1'b0};
              sram_be_n <= half_be_n(wb_sel_i, 1'b0);
              sram_ce_n <= 1'b0;
              sram_oe_n <= 1'b0;
              state_r   <= ST_LO_ACC;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_be_n  <= 2'b11;
            sram_dq_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
